// File: rtl/lsu_mem_resp.sv
// lsu_mem_resp: backing data memory for core-only simulation of the LSU.
// The block takes one load or store at a time and holds it for LATENCY
// cycles. It then commits the access to a word-addressed, byte-maskable
// array and returns a single-cycle response pulse.
//
// Ports:
//   clock             rising-edge clock
//   reset             synchronous active-low reset
//   io_lsu_reqValid   request valid, held by the core until the response
//   io_lsu_addr       byte address
//   io_lsu_size       access size (captured only; reads return a full word)
//   io_lsu_wen        1 = store, 0 = load
//   io_lsu_wdata      lane-aligned store data
//   io_lsu_wmask      byte-lane write enables
//   io_lsu_respValid  one-cycle response pulse
//   io_lsu_rdata      load data, valid with respValid, held afterwards
//   io_lsu_fault      address outside [BASE, BASE+4*DEPTH), valid with respValid
module lsu_mem_resp #(
    parameter int unsigned DEPTH   = 1024,
    parameter logic [31:0] BASE    = 32'h8000_0000,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_lsu_reqValid,
    input  logic [31:0] io_lsu_addr,
    input  logic [1:0]  io_lsu_size,
    input  logic        io_lsu_wen,
    input  logic [31:0] io_lsu_wdata,
    input  logic [3:0]  io_lsu_wmask,
    output logic        io_lsu_respValid,
    output logic [31:0] io_lsu_rdata,
    output logic        io_lsu_fault
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic [31:0]    r_addr;
    logic           r_wen;
    logic [31:0]    r_wdata;
    logic [3:0]     r_wmask;
    logic [1:0]     r_size;
    logic           r_resp;
    logic [31:0]    r_rdata;
    logic           r_fault;
    logic [31:0]    r_mem [DEPTH];

    logic           w_fresh;
    logic [31:0]    w_addr;
    logic           w_wen;
    logic [31:0]    w_wdata;
    logic [3:0]     w_wmask;
    logic [31:0]    w_off;
    logic           w_inrange;
    logic [AW-1:0]  w_idx;
    logic           w_commit;
    logic           w_unused;

    // With LATENCY==1 the accepting edge is also the commit edge. The
    // request registers are not loaded yet at that edge, so the live
    // inputs are used while in IDLE.
    assign w_fresh   = (r_state == S_IDLE);
    assign w_addr    = w_fresh ? io_lsu_addr  : r_addr;
    assign w_wen     = w_fresh ? io_lsu_wen   : r_wen;
    assign w_wdata   = w_fresh ? io_lsu_wdata : r_wdata;
    assign w_wmask   = w_fresh ? io_lsu_wmask : r_wmask;

    assign w_off     = w_addr - BASE;
    assign w_inrange = (w_off[31:AW+2] == '0);
    assign w_idx     = w_off[AW+1:2];

    // Asserted on the edge that enters RESP. Gating with reset means a reset
    // on that same edge aborts the access.
    assign w_commit  = reset &&
                       (((r_state == S_IDLE) && io_lsu_reqValid && (LATENCY == 1)) ||
                        ((r_state == S_WAIT) && (r_cnt == CW'(1))));

    assign w_unused  = ^{r_size, w_off[1:0]};

    always_ff @(posedge clock) begin
        if (w_commit && w_wen && w_inrange) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (w_wmask[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_resp  <= 1'b0;
            r_rdata <= '0;
            r_fault <= 1'b0;
        end else begin
            r_resp  <= w_commit;
            r_fault <= w_commit && !w_inrange;
            if (w_commit) begin
                r_rdata <= (!w_wen && w_inrange) ? r_mem[w_idx] : '0;
            end
            case (r_state)
                S_IDLE: begin
                    if (io_lsu_reqValid) begin
                        r_addr  <= io_lsu_addr;
                        r_wen   <= io_lsu_wen;
                        r_wdata <= io_lsu_wdata;
                        r_wmask <= io_lsu_wmask;
                        r_size  <= io_lsu_size;
                        if (LATENCY == 1) begin
                            r_state <= S_RESP;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= CNT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == CW'(1)) begin
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign io_lsu_respValid = r_resp;
    assign io_lsu_rdata     = r_rdata;
    assign io_lsu_fault     = r_fault;

endmodule
